// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch controller states (BOOT, RUN, FLUSH)
//   INSTR_BYTES   : PC increment per fetched word
//   NOP_INSTR     : instruction presented when nothing valid is held
//   fetch_entry_t : one fetch-buffer slot (PC tag, instruction word, filled flag)
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam int              INSTR_BYTES = 4;
    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Circular buffer holding fetched instructions and their PCs.
// Slots are reserved at the tail when a request is granted, filled in order
// when the response returns, and popped from the head when decode accepts.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear_i           : drop every slot (redirect)
//   reserve_i/_pc_i   : allocate the tail slot tagged with a PC
//   fill_i/_data_i    : write the oldest reserved-but-unfilled slot
//   pop_i             : release the head slot
//   head_o            : head slot contents
//   occupancy_o       : number of filled (buffered) slots
//   pending_o         : number of reserved slots still awaiting data
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       reserve_i,
    input  logic [XLEN-1:0]            reserve_pc_i,
    input  logic                       fill_i,
    input  logic [XLEN-1:0]            fill_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Pointers carry an extra wrap bit so equal indices can mean empty or full.
    logic [PW:0]  head_q, fill_q, tail_q;
    fetch_entry_t mem_q [DEPTH];

    // Advance a pointer; wraps explicitly so non-power-of-two depths work.
    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(DEPTH - 1)) begin
            return {~p[PW], PW'(0)};
        end
        return {p[PW], p[PW-1:0] + 1'b1};
    endfunction

    // Number of slots from pointer b up to (not including) pointer a.
    function automatic logic [CW-1:0] ptr_dist(input logic [PW:0] a, input logic [PW:0] b);
        int d;
        if (a[PW] == b[PW]) begin
            d = int'(a[PW-1:0]) - int'(b[PW-1:0]);
        end else begin
            d = DEPTH - int'(b[PW-1:0]) + int'(a[PW-1:0]);
        end
        return CW'(d);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
            end
        end else if (clear_i) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].filled <= 1'b0;
            end
        end else begin
            // Reserve, fill and pop always address distinct slots: reserve
            // only happens when not full, fill only when a slot is pending,
            // pop only when the head is already filled.
            if (reserve_i) begin
                mem_q[tail_q[PW-1:0]].pc     <= reserve_pc_i;
                mem_q[tail_q[PW-1:0]].filled <= 1'b0;
                tail_q                       <= ptr_inc(tail_q);
            end
            if (fill_i) begin
                mem_q[fill_q[PW-1:0]].instr  <= fill_data_i;
                mem_q[fill_q[PW-1:0]].filled <= 1'b1;
                fill_q                       <= ptr_inc(fill_q);
            end
            if (pop_i) begin
                mem_q[head_q[PW-1:0]].filled <= 1'b0;
                head_q                       <= ptr_inc(head_q);
            end
        end
    end

    always_comb begin
        head_o      = mem_q[head_q[PW-1:0]];
        occupancy_o = ptr_dist(fill_q, head_q);
        pending_o   = ptr_dist(tail_q, fill_q);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to instruction
// memory, buffers returned words and hands them to decode. A redirect from
// downstream flushes wrong-path work and restarts fetch at the target.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt  : fetch request channel
//   imem_rvalid/imem_rdata       : in-order response channel
//   redirect/redirect_target     : taken branch/jump from downstream
//   instr_valid/instr/pc_out     : instruction handed to decode
//   instr_ready                  : decode accepts the instruction
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]         occupancy, pending;
    fetch_entry_t          head;
    logic                  grant, fill, pop, rsp_due;
    logic                  unused_tgt_lsbs;

    // Targets are forced to word alignment; the dropped bits are not trapped.
    assign unused_tgt_lsbs = ^redirect_target[1:0];

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst),
        .clear_i      (redirect),
        .reserve_i    (grant),
        .reserve_pc_i (fetch_pc_q),
        .fill_i       (fill),
        .fill_data_i  (imem_rdata),
        .pop_i        (pop),
        .head_o       (head),
        .occupancy_o  (occupancy),
        .pending_o    (pending)
    );

    always_comb begin
        // Pending requests plus buffered words never exceed the buffer size,
        // so every granted request already owns the slot its data lands in.
        imem_req  = (state_q == RUN) && !redirect &&
                    (({1'b0, pending} + {1'b0, occupancy}) < (CW + 1)'(DEPTH));
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;

        // A response is only meaningful if something is still owed to us.
        rsp_due   = imem_rvalid && ((pending != '0) || (drop_cnt_q != '0));
        fill      = imem_rvalid && (state_q == RUN) && (pending != '0) && !redirect;

        instr_valid = head.filled && !redirect;
        pop         = instr_valid && instr_ready;
        instr       = head.filled ? head.instr : NOP_INSTR;
        pc_out      = head.filled ? head.pc : '0;

        // On redirect every request still in flight becomes a response to
        // discard; a response arriving in the same cycle is already gone.
        if (redirect) begin
            drop_cnt_d = drop_cnt_q + pending - CW'(rsp_due);
        end else if ((state_q == FLUSH) && rsp_due) begin
            drop_cnt_d = drop_cnt_q - 1'b1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect) begin
            fetch_pc_d = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
        end else if (grant) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     if (redirect && (drop_cnt_d != '0)) state_q <= FLUSH;
                FLUSH:   if (drop_cnt_d == '0) state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response nobody is waiting for is ignored, but it means the memory
    // side has broken the in-order one-response-per-grant contract.
    a_no_spurious_rvalid : assert property (
        @(posedge clk) disable iff (!rst)
        !(imem_rvalid && (pending == '0) && (drop_cnt_q == '0))
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-based reference model:
// memory is an in-order queue of granted requests, the correct path is the
// list of addresses granted since the last redirect, and every memory
// response that is still owed when a redirect happens is expected to vanish.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect, instr_valid, instr_ready;
    logic [31:0] redirect_target, instr, pc_out;

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc_out          (pc_out),
        .instr_ready     (instr_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          rdy;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] path_addr[$];
    logic [31:0] path_data[$];
    int          drop_owed;
    bit          booted;
    logic [31:0] next_pc;
    int          cyc;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        path_addr.delete();
        path_data.delete();
        drop_owed = 0;
        booted    = 1'b0;
        next_pc   = RESET_PC;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        model_reset();
        repeat (3) begin
            #1;
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, NOP);
            chk("rst_pc_out", pc_out, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic cycle(input int n);
        bit          g, rv, rd, rdy, allow, exp_req, exp_valid;
        logic [31:0] tgt;
        mreq_t       m;
        @(negedge clk);
        rst = 1'b1;
        tgt = $urandom;
        if (n < 40) begin
            // Streaming: memory always grants, decode always ready.
            g = 1; rdy = 1; rd = 0; allow = 1;
        end else if (n < 60) begin
            // Backpressure window followed by release.
            g = 1; rdy = !(n >= 40 && n < 45); rd = 0; allow = 1;
        end else if (n < 100) begin
            // Responses held back so two requests are in flight when the
            // first redirect lands; a second redirect arrives mid-flush.
            g = 1; rdy = 1;
            rd    = (n == 70) || (n == 74);
            tgt   = (n == 70) ? 32'h0000_0043 : 32'h0000_0080;
            allow = !(n >= 66 && n <= 75) || (n == 73);
        end else begin
            g     = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 9) < 7);
            rd    = ($urandom_range(0, 24) == 0);
            allow = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        end
        rv = allow && (memq.size() > 0) && (memq.size() == 0 ? 1'b0 : memq[0].rdy <= cyc);

        imem_gnt        = g;
        imem_rvalid     = rv;
        imem_rdata      = rv ? memq[0].data : $urandom;
        redirect        = rd;
        redirect_target = tgt;
        instr_ready     = rdy;
        #1;

        exp_req   = booted && (drop_owed == 0) && !rd && (path_addr.size() < DEPTH);
        exp_valid = !rd && (path_data.size() > 0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, next_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("pc_out", pc_out, path_addr[0]);
            chk("instr", instr, path_data[0]);
        end

        @(posedge clk);
        if (rv) begin
            m = memq.pop_front();
            if (drop_owed > 0) drop_owed--;
            else path_data.push_back(m.data);
        end
        if (exp_valid && rdy) begin
            void'(path_addr.pop_front());
            void'(path_data.pop_front());
        end
        if (exp_req && g) begin
            memq.push_back('{addr: next_pc, data: $urandom, rdy: cyc + 1});
            path_addr.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
        if (rd) begin
            path_addr.delete();
            path_data.delete();
            drop_owed = memq.size();
            next_pc   = {tgt[31:2], 2'b00};
        end
        booted = 1'b1;
        cyc++;
    endtask

    initial begin
        cyc             = 0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        redirect        = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if (n == 1500) do_reset();
            cycle(n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
